// File: rtl/danmaku_pkg.sv
// Shared constants, FIFO word formats and writer FSM states for the danmaku pixel FIFO producer.
package danmaku_pkg;

    localparam logic [31:0] MARK_H = 32'h0000_0001;
    localparam logic [31:0] MARK_V = 32'h0000_0002;

    localparam int PIX_RGB_MSB = 31;
    localparam int PIX_RGB_LSB = 8;
    localparam int PIX_OPQ_BIT = 7;

    // Pixel words always carry 00 in the tag bits so they can never alias a marker.
    localparam logic [31:0] PIX_TAG_MASK = 32'h0000_0003;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_VMARK = 3'd1,
        ST_LINE  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HMARK = 3'd4
    } wr_state_t;

    function automatic logic [31:0] pix_word(input logic [31:0] rd);
        return rd & ~PIX_TAG_MASK;
    endfunction

    function automatic logic [31:0] tp_word(input logic [7:0] x, input logic [7:0] y);
        logic [31:0] w;
        w = '0;
        w[PIX_RGB_MSB:PIX_RGB_LSB] = {x, y, x ^ y};
        w[PIX_OPQ_BIT] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/danmaku_read_credit.sv
// Outstanding-read counter plus the compare that permits the next memory read.
// Permission is combinational off the registered count; FIFO fill level provides the backpressure.
module danmaku_read_credit #(
    parameter int FIFO_DEPTH = 512,
    parameter int USEDW_W    = 9,
    parameter int MAX_PEND   = 8,
    parameter int MARGIN     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_acc,
    input  logic               rsp_vld,
    input  logic [USEDW_W-1:0] fifo_usedw,
    output logic               issue_ok,
    output logic               pend_zero
);

    localparam int PEND_W = $clog2(MAX_PEND + 1);
    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

    logic [PEND_W-1:0] pend;
    logic [31:0]       inflight;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= '0;
        end else if (req_acc && !rsp_vld) begin
            pend <= pend + PEND_ONE;
        end else if (!req_acc && rsp_vld && (pend != '0)) begin
            pend <= pend - PEND_ONE;
        end
    end

    // A request accepted this cycle is not in pend yet but already owns a FIFO slot.
    assign inflight  = 32'(pend) + 32'(req_acc);
    assign issue_ok  = (inflight < 32'(MAX_PEND)) &&
                       ((32'(fifo_usedw) + inflight + 32'd1) <= 32'(FIFO_DEPTH - MARGIN));
    assign pend_zero = (pend == '0);

endmodule

// File: rtl/danmaku_fifo_writer.sv
// Reads the overlay framebuffer and writes pixels plus V/H sync markers into the pixel FIFO; 1 cycle readdata->FIFO.
// Reads are throttled by FIFO credit and MAX_PEND; DANMAKU_WRITER_TESTPATTERN_EN adds a memory-free test pattern.
module danmaku_fifo_writer
    import danmaku_pkg::*;
#(
    parameter int FIFO_DEPTH = 512,
    parameter int USEDW_W    = 9,
    parameter int MAX_PEND   = 8,
    parameter int MARGIN     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [31:0]        fb_base,
    input  logic [15:0]        screenX,
    input  logic [15:0]        screenY,
    output logic [31:0]        mem_addr,
    output logic               mem_read,
    input  logic               mem_waitrequest,
    input  logic [31:0]        mem_readdata,
    input  logic               mem_readdatavalid,
    output logic [31:0]        fifoData_o,
    output logic               fifoWrreq,
    input  logic               fifoWrfull,
    input  logic [USEDW_W-1:0] fifoWrusedw,
    output logic               busy,
`ifdef DANMAKU_WRITER_TESTPATTERN_EN
    input  logic               test_pattern,
`endif
    output logic               frame_done
);

    wr_state_t   state_q, state_d;
    logic [15:0] sx_q, sy_q, x_q, y_q;
    logic [31:0] rd_addr_q;
    logic        issue_ok, pend_zero, req_acc, slot_free, mark_ok, start_ok;
    logic        launch, mark_wr, tp_wr, frame_end, next_line;
    logic [31:0] mark_dat;
`ifdef DANMAKU_WRITER_TESTPATTERN_EN
    logic        tp_q;
`endif

    assign req_acc   = mem_read && !mem_waitrequest;
    assign slot_free = !mem_read || !mem_waitrequest;
    assign mark_ok   = !fifoWrfull && (32'(fifoWrusedw) < 32'(FIFO_DEPTH - 1));
    assign start_ok  = enable && (screenX != 16'd0) && (screenY != 16'd0);
    assign busy      = (state_q != ST_IDLE);

    danmaku_read_credit #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .USEDW_W    (USEDW_W),
        .MAX_PEND   (MAX_PEND),
        .MARGIN     (MARGIN)
    ) u_credit (
        .clk        (clk),
        .rst        (rst),
        .req_acc    (req_acc),
        .rsp_vld    (mem_readdatavalid),
        .fifo_usedw (fifoWrusedw),
        .issue_ok   (issue_ok),
        .pend_zero  (pend_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        launch    = 1'b0;
        mark_wr   = 1'b0;
        mark_dat  = MARK_V;
        tp_wr     = 1'b0;
        frame_end = 1'b0;
        next_line = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) state_d = ST_VMARK;
            end
            ST_VMARK: begin
                if (mark_ok) begin
                    mark_wr = 1'b1;
                    state_d = ST_LINE;
                end
            end
            ST_LINE: begin
                if (x_q == sx_q) begin
                    state_d = ST_DRAIN;
                end else begin
`ifdef DANMAKU_WRITER_TESTPATTERN_EN
                    if (tp_q) tp_wr = issue_ok;
                    else      launch = slot_free && issue_ok;
`else
                    launch = slot_free && issue_ok;
`endif
                end
            end
            ST_DRAIN: begin
                // The last request may still be stalled at the port, so wait for it too.
                if (pend_zero && !mem_read) begin
                    if (y_q == sy_q - 16'd1) begin
                        frame_end = 1'b1;
                        state_d   = start_ok ? ST_VMARK : ST_IDLE;
                    end else begin
                        next_line = 1'b1;
                        state_d   = ST_HMARK;
                    end
                end
            end
            ST_HMARK: begin
                if (mark_ok) begin
                    mark_wr  = 1'b1;
                    mark_dat = MARK_H;
                    state_d  = ST_LINE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sx_q       <= '0;
            sy_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            rd_addr_q  <= '0;
            mem_read   <= 1'b0;
            mem_addr   <= '0;
            fifoWrreq  <= 1'b0;
            fifoData_o <= '0;
            frame_done <= 1'b0;
`ifdef DANMAKU_WRITER_TESTPATTERN_EN
            tp_q       <= 1'b0;
`endif
        end else begin
            if (state_q == ST_VMARK) begin
                sx_q      <= screenX;
                sy_q      <= screenY;
                rd_addr_q <= fb_base;
                x_q       <= '0;
                y_q       <= '0;
`ifdef DANMAKU_WRITER_TESTPATTERN_EN
                tp_q      <= test_pattern;
`endif
            end
            if (next_line) begin
                y_q <= y_q + 16'd1;
                x_q <= '0;
            end
            // Request and address only move once the previous request has been taken.
            if (slot_free) begin
                mem_read <= launch;
                if (launch) mem_addr <= rd_addr_q;
            end
            if (launch) begin
                rd_addr_q <= rd_addr_q + 32'd4;
                x_q       <= x_q + 16'd1;
            end
            fifoWrreq <= mem_readdatavalid || mark_wr || tp_wr;
            if (mem_readdatavalid) begin
                fifoData_o <= pix_word(mem_readdata);
            end else if (mark_wr) begin
                fifoData_o <= mark_dat;
            end
`ifdef DANMAKU_WRITER_TESTPATTERN_EN
            if (tp_wr) begin
                fifoData_o <= tp_word(x_q[7:0], y_q[7:0]);
                x_q        <= x_q + 16'd1;
            end
`endif
            frame_done <= frame_end;
        end
    end

    // Pixel writes are unconditional; the credit compare must keep them away from a full FIFO.
    always_ff @(posedge clk) begin
        if (rst && mem_readdatavalid) begin
            assert (!fifoWrfull);
        end
    end

endmodule

// File: tb/tb_danmaku_fifo_writer.sv
// Randomised bench for danmaku_fifo_writer: memory model with in-order random latency, FIFO stream scoreboard.
module tb_danmaku_fifo_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [31:0] fb_base;
    logic [15:0] screenX, screenY;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        mem_readdatavalid;
    logic [31:0] fifoData_o;
    logic        fifoWrreq;
    logic        fifoWrfull;
    logic [8:0]  fifoWrusedw;
    logic        busy;
    logic        frame_done;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] mq[$];
    int          mdue[$];
    int          cyc = 0;
    int          acc_cnt = 0;
    int          fd_cnt = 0;
    int          out_cnt = 0;
    int          max_out = 0;
    int          hold_viol = 0;
    int          lat_max = 1;
    bit          mem_hold = 1'b0;
    logic [31:0] mem_xor = 32'h0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    danmaku_fifo_writer dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .fb_base           (fb_base),
        .screenX           (screenX),
        .screenY           (screenY),
        .mem_addr          (mem_addr),
        .mem_read          (mem_read),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .fifoData_o        (fifoData_o),
        .fifoWrreq         (fifoWrreq),
        .fifoWrfull        (fifoWrfull),
        .fifoWrusedw       (fifoWrusedw),
        .busy              (busy),
        .frame_done        (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Memory slave plus FIFO/port monitor: observe at negedge, drive #1 after posedge.
    initial begin
        mem_readdatavalid = 1'b0;
        mem_readdata      = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mq.delete();
                mdue.delete();
                out_cnt    = 0;
                prev_stall = 1'b0;
            end else begin
                if (mem_readdatavalid) out_cnt--;
                if (prev_stall && (!mem_read || mem_addr != prev_addr)) hold_viol++;
                prev_stall = mem_read && mem_waitrequest;
                prev_addr  = mem_addr;
                if (mem_read && !mem_waitrequest) begin
                    mq.push_back(mem_addr);
                    mdue.push_back(cyc + $urandom_range(1, lat_max));
                    acc_cnt++;
                    out_cnt++;
                end
                if (out_cnt > max_out) max_out = out_cnt;
                if (fifoWrreq) got_q.push_back(fifoData_o);
                if (frame_done) fd_cnt++;
            end
            cyc++;
            @(posedge clk);
            #1;
            if (rst && !mem_hold && mq.size() > 0 && mdue[0] <= cyc) begin
                mem_readdatavalid = 1'b1;
                mem_readdata      = mq.pop_front() ^ mem_xor;
                void'(mdue.pop_front());
            end else begin
                mem_readdatavalid = 1'b0;
            end
        end
    end

    // Reference: V marker, line 0, then H marker before each further line; pixels from a linear 32-bit address walk.
    task automatic build_exp(input logic [31:0] base, input int sx, input int sy);
        logic [31:0] a;
        a = base;
        exp_q.push_back(32'h0000_0002);
        for (int y = 0; y < sy; y++) begin
            if (y > 0) exp_q.push_back(32'h0000_0001);
            for (int x = 0; x < sx; x++) begin
                exp_q.push_back((a ^ mem_xor) & 32'hFFFF_FFFC);
                a = a + 32'd4;
            end
        end
    endtask

    task automatic cmp_stream(input string tag);
        check({tag, "_len"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic start_frame(input logic [31:0] base, input int sx, input int sy);
        fb_base = base;
        screenX = 16'(sx);
        screenY = 16'(sy);
        enable  = 1'b1;
        for (int i = 0; i < 20 && !busy; i++) tick(1);
        check("start_busy", busy, 1'b1);
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 3000 && fd_cnt < target; i++) tick(1);
        check("frame_done_seen", fd_cnt >= target, 1'b1);
    endtask

    task automatic run_frame(input string tag, input logic [31:0] base, input int sx, input int sy,
                             input int nfr, input bit stall);
        int fd0;
        got_q.delete();
        exp_q.delete();
        max_out   = 0;
        hold_viol = 0;
        fd0       = fd_cnt;
        for (int f = 0; f < nfr; f++) build_exp(base, sx, sy);
        start_frame(base, sx, sy);
        if (nfr == 1) enable = 1'b0;
        if (stall) begin
            tick($urandom_range(0, 6));
            mem_waitrequest = 1'b1;
            tick(5);
            mem_waitrequest = 1'b0;
        end
        if (nfr > 1) begin
            wait_done(fd0 + nfr - 1);
            enable = 1'b0;
        end
        wait_done(fd0 + nfr);
        tick(20);
        check({tag, "_idle_busy"}, busy, 1'b0);
        check({tag, "_done_pulses"}, fd_cnt - fd0, nfr);
        check({tag, "_pend_le_max"}, max_out <= 8, 1'b1);
        check({tag, "_addr_hold"}, hold_viol, 0);
        cmp_stream(tag);
    endtask

    initial begin
        int a0, fd0;
        logic [31:0] first;
        rst             = 1'b0;
        enable          = 1'b0;
        fb_base         = 32'h0;
        screenX         = 16'd0;
        screenY         = 16'd0;
        mem_waitrequest = 1'b0;
        fifoWrfull      = 1'b0;
        fifoWrusedw     = 9'd0;
        tick(3);
        check("rst_mem_read", mem_read, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_fifo_wrreq", fifoWrreq, 1'b0);
        check("rst_fifo_data", fifoData_o, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        rst = 1'b1;
        tick(3);

        // Basic 4x2 frame, data equals address; enable is dropped during line 0.
        run_frame("f4x2", 32'h0000_1000, 4, 2, 1, 1'b0);

        // Opaque bit kept, tag bits cleared.
        mem_xor = 32'h0000_1000 ^ 32'hAABB_CC83;
        run_frame("opaque", 32'h0000_1000, 1, 1, 1, 1'b0);
        first = (got_q.size() > 1) ? got_q[1] : 32'hDEAD_BEEF;
        check("opaque_word", first, 32'hAABB_CC80);
        mem_xor = 32'h0;

        // Back-to-back frames with enable held across the frame boundary.
        lat_max = 3;
        run_frame("b2b", 32'h0000_4000, 2, 2, 2, 1'b0);

        // Credit: no reads at usedw = DEPTH-MARGIN, exactly three after it drops by 3.
        got_q.delete();
        exp_q.delete();
        fd0         = fd_cnt;
        mem_hold    = 1'b1;
        fifoWrusedw = 9'd508;
        build_exp(32'h0000_3000, 16, 1);
        start_frame(32'h0000_3000, 16, 1);
        enable = 1'b0;
        a0 = acc_cnt;
        tick(20);
        check("credit_blocked", acc_cnt - a0, 0);
        fifoWrusedw = 9'd505;
        tick(20);
        check("credit_three", acc_cnt - a0, 3);
        fifoWrusedw = 9'd0;
        mem_hold    = 1'b0;
        wait_done(fd0 + 1);
        tick(20);
        cmp_stream("credit");

        // Random frames with a 5-cycle waitrequest burst and 1..10 cycle read latency.
        lat_max = 10;
        for (int f = 0; f < 6; f++) begin
            mem_xor = $urandom;
            run_frame($sformatf("rnd%0d", f),
                      (f == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC),
                      $urandom_range(1, 8), $urandom_range(1, 4), 1, 1'b1);
        end
        mem_xor = 32'h0;

        // Reset mid-line, then a clean frame starting with a V marker.
        lat_max = 3;
        a0 = acc_cnt;
        start_frame(32'h0000_2000, 8, 2);
        enable = 1'b0;
        for (int i = 0; i < 50 && acc_cnt == a0; i++) tick(1);
        tick(2);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_mem_read", mem_read, 1'b0);
        check("mid_rst_mem_addr", mem_addr, 32'h0);
        check("mid_rst_fifo_wrreq", fifoWrreq, 1'b0);
        check("mid_rst_fifo_data", fifoData_o, 32'h0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_frame_done", frame_done, 1'b0);
        tick(3);
        got_q.delete();
        rst = 1'b1;
        tick(1);
        exp_q.delete();
        build_exp(32'h0000_2000, 8, 2);
        fd0 = fd_cnt;
        start_frame(32'h0000_2000, 8, 2);
        enable = 1'b0;
        wait_done(fd0 + 1);
        tick(20);
        first = (got_q.size() > 0) ? got_q[0] : 32'hDEAD_BEEF;
        check("post_rst_first", first, 32'h0000_0002);
        cmp_stream("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
